// File: rtl/switch_debouncer_pkg.sv
// Purpose: shared constants and types for the slide-switch debouncer.
//   DEBOUNCE_10MS_50MHZ : 10 ms qualification window at a 50 MHz clock.
//   db_state_e          : per-bit debounce FSM states.
package switch_debouncer_pkg;

  localparam int DEBOUNCE_10MS_50MHZ = 500000;

  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_e;

endpackage

// File: rtl/switch_debounce_bit.sv
// Purpose: one switch bit -- 2-FF synchroniser followed by a stable-level
//   qualifier. A new level is accepted only after it has been seen on the
//   synchronised input for STABLE_CYCLES consecutive clocks.
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   i_raw     : asynchronous switch pin
//   o_stable  : debounced level
//   o_changed : one-cycle pulse in the cycle o_stable takes a new value
module switch_debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_10MS_50MHZ,  // >= 1
  parameter int CNT_W         = 19                    // 2**CNT_W > STABLE_CYCLES-1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_changed
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1, r_sync2;
  logic             r_stable, r_changed;
  logic [CNT_W-1:0] r_cnt;
  db_state_e        r_state;

  logic             w_stable_nxt, w_changed_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  db_state_e        w_state_nxt;

  // Synchroniser FFs are kept back-to-back with nothing in between so the
  // metastability settling window is a full clock period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_stable  <= 1'b0;
      r_changed <= 1'b0;
      r_cnt     <= '0;
      r_state   <= DB_IDLE;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_stable  <= w_stable_nxt;
      r_changed <= w_changed_nxt;
      r_cnt     <= w_cnt_nxt;
      r_state   <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_stable_nxt  = r_stable;
    w_changed_nxt = 1'b0;
    case (r_state)
      DB_IDLE: begin
        if (r_sync2 != r_stable) begin
          if (STABLE_CYCLES == 1) begin
            // Single-cycle window: the first differing sample qualifies.
            w_stable_nxt  = r_sync2;
            w_changed_nxt = 1'b1;
            w_cnt_nxt     = '0;
          end else begin
            w_state_nxt = DB_COUNT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      DB_COUNT: begin
        if (r_sync2 == r_stable) begin
          // Bounced back to the accepted level: discard progress.
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_stable_nxt  = r_sync2;
          w_changed_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = DB_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = DB_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_stable  = r_stable;
  assign o_changed = r_changed;

endmodule

// File: rtl/switch_debouncer.sv
// Purpose: conditions the board slide switches for the switch PIO in_port.
//   Every bit is synchronised and debounced independently.
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   sw_raw     : asynchronous switch pins [WIDTH]
//   sw_stable  : debounced levels, to PIO in_port [WIDTH]
//   sw_changed : per-bit one-cycle pulse when sw_stable toggles [WIDTH]
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int STABLE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int CNT_W         = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_changed
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    switch_debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (sw_raw[g]),
      .o_stable  (sw_stable[g]),
      .o_changed (sw_changed[g])
    );
  end

endmodule
